series_controller: RTL and testbench

- Moore-style sequencer for the Taylor-series hyperbolic datapath: cosh(x) = sum x^2n/(2n)! and sinh(x) = sum x^(2n+1)/(2n+1)!.
- Drives register load/init strobes, mux selects and the term counter that addresses the coefficient ROM; exposes a start/busy/ready handshake to the host.
- Sits between the host and the existing datapath registers: x2 (x squared), temp (current term) and the adder/accumulator.

---
 rtl/series_controller.sv | 136 +++++++++++++
 tb/tb_series_controller.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/series_controller.sv
// Sequencer for the cosh/sinh Taylor-series datapath (x2, temp, accumulator).
// Define SERIES_ABORT_EN to add an abort input that cancels a running series.
module series_controller #(
  parameter int TERMS = 8,
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
`ifdef SERIES_ABORT_EN
  input  logic             abort,
`endif
  output logic [CNT_W-1:0] count,
  output logic             mode_q,
  output logic             xsel,
  output logic             x2sel,
  output logic             tempsel,
  output logic             romsel,
  output logic             x2ln,
  output logic             x2init0,
  output logic             x2init1,
  output logic             templn,
  output logic             tempinit0,
  output logic             tempinit1,
  output logic             addln,
  output logic             addinit0,
  output logic             addinit1,
  output logic             firstterm,
  output logic             busy,
  output logic             ready
);

  typedef enum logic [2:0] {
    IDLE, LOAD, ADD, MULX, MULR, DONE
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TERMS - 1);

  state_t state, next;
  logic   accept;
  logic   abort_hit;

  assign accept = (state == IDLE) && start;

`ifdef SERIES_ABORT_EN
  assign abort_hit = abort && (state == LOAD || state == ADD ||
                               state == MULX || state == MULR);
`else
  assign abort_hit = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next;
  end

  always_comb begin
    next = state;
    unique case (state)
      IDLE:    if (start) next = LOAD;
      LOAD:    next = ADD;
      ADD:     next = (count == LAST) ? DONE : MULX;
      MULX:    next = MULR;
      MULR:    next = ADD;
      DONE:    next = IDLE;
      default: next = IDLE;
    endcase
    if (abort_hit) next = IDLE;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count  <= '0;
      mode_q <= 1'b0;
      ready  <= 1'b0;
    end else begin
      if (accept) begin
        count  <= '0;
        mode_q <= mode;
        ready  <= 1'b0;
      end else if (abort_hit) begin
        count  <= '0;
      end else if (state == MULR) begin
        count  <= count + CNT_W'(1);
      end
      if (state == DONE) ready <= 1'b1;
    end
  end

  always_comb begin
    xsel      = 1'b0;
    x2sel     = 1'b0;
    tempsel   = 1'b0;
    romsel    = 1'b0;
    x2ln      = 1'b0;
    x2init0   = 1'b0;
    x2init1   = 1'b0;
    templn    = 1'b0;
    tempinit0 = 1'b0;
    tempinit1 = 1'b0;
    addln     = 1'b0;
    addinit0  = 1'b0;
    addinit1  = 1'b0;
    firstterm = 1'b0;
    busy      = 1'b0;
    unique case (state)
      LOAD: begin
        busy      = 1'b1;
        x2ln      = 1'b1;
        addinit0  = 1'b1;
        templn    = 1'b1;
        // cosh seeds temp with 1.0, sinh seeds it with x
        tempinit1 = !mode_q;
        xsel      = mode_q;
      end
      ADD: begin
        busy      = 1'b1;
        addln     = 1'b1;
        firstterm = (count == '0);
      end
      MULX: begin
        busy    = 1'b1;
        templn  = 1'b1;
        tempsel = 1'b1;
      end
      MULR: begin
        busy   = 1'b1;
        templn = 1'b1;
        romsel = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_series_controller.sv
// Self-checking bench for series_controller with TERMS=8.
// Vector table for idle/cosh/sinh runs, plus reset and abort sequences.
module tb_series_controller;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic       mode;
`ifdef SERIES_ABORT_EN
  logic       abort;
`endif
  logic [3:0] count;
  logic       mode_q;
  logic       xsel, x2sel, tempsel, romsel;
  logic       x2ln, x2init0, x2init1;
  logic       templn, tempinit0, tempinit1;
  logic       addln, addinit0, addinit1;
  logic       firstterm, busy, ready;

  int checks = 0;
  int failures = 0;

  series_controller #(.TERMS(8), .CNT_W(4)) dut (
    .clock(clock), .reset(reset), .start(start), .mode(mode),
`ifdef SERIES_ABORT_EN
    .abort(abort),
`endif
    .count(count), .mode_q(mode_q),
    .xsel(xsel), .x2sel(x2sel), .tempsel(tempsel), .romsel(romsel),
    .x2ln(x2ln), .x2init0(x2init0), .x2init1(x2init1),
    .templn(templn), .tempinit0(tempinit0), .tempinit1(tempinit1),
    .addln(addln), .addinit0(addinit0), .addinit1(addinit1),
    .firstterm(firstterm), .busy(busy), .ready(ready)
  );

  always #5 clock = ~clock;

  // {busy,ready,firstterm,xsel,x2sel,tempsel,romsel,x2ln,
  //  x2init0,x2init1,templn,tempinit0,tempinit1,addln,addinit0,addinit1}
  localparam logic [15:0] O_IDLE  = 16'h0000;
  localparam logic [15:0] O_RDY   = 16'h4000;
  localparam logic [15:0] O_LOADC = 16'h812A;
  localparam logic [15:0] O_LOADS = 16'h9122;
  localparam logic [15:0] O_ADD0  = 16'hA004;
  localparam logic [15:0] O_ADD   = 16'h8004;
  localparam logic [15:0] O_MULX  = 16'h8420;
  localparam logic [15:0] O_MULR  = 16'h8220;
  localparam logic [15:0] O_DONE  = 16'h0000;

  typedef struct {
    logic        start;
    logic        mode;
    logic [15:0] outs;
    logic [3:0]  cnt;
    logic        mq;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [15:0] pack();
    return {busy, ready, firstterm, xsel, x2sel, tempsel, romsel, x2ln,
            x2init0, x2init1, templn, tempinit0, tempinit1,
            addln, addinit0, addinit1};
  endfunction

  task automatic chk(input string name, input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic push(input logic s, input logic m, input logic [15:0] o,
                      input logic [3:0] c, input logic q);
    vec_t v;
    v.start = s; v.mode = m; v.outs = o; v.cnt = c; v.mq = q;
    tbl.push_back(v);
  endtask

  // One complete 8-term run followed by three idle cycles with ready held.
  task automatic push_run(input logic m, input bit toggle, input int pulse_at);
    int j = 1;
    push(1'b1, m, m ? O_LOADS : O_LOADC, 4'd0, m);
    for (int i = 0; i < 8; i++) begin
      push(j == pulse_at, toggle ? j[0] : m, i == 0 ? O_ADD0 : O_ADD,
           4'(i), m);
      j++;
      if (i < 7) begin
        push(j == pulse_at, toggle ? j[0] : m, O_MULX, 4'(i), m); j++;
        push(j == pulse_at, toggle ? j[0] : m, O_MULR, 4'(i), m); j++;
      end
    end
    push(1'b0, toggle ? j[0] : m, O_DONE, 4'd7, m);
    for (int k = 0; k < 3; k++) push(1'b0, 1'b0, O_RDY, 4'd7, m);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Issues a start pulse and returns edges until ready (0 = start edge).
  task automatic run_latency(input logic m, output int n);
    start = 1'b1; mode = m;
    step();
    start = 1'b0;
    n = 0;
    while (!ready && n < 100) begin
      step();
      n++;
    end
  endtask

  initial begin
    int n;
    reset = 1'b0; start = 1'b0; mode = 1'b0;
`ifdef SERIES_ABORT_EN
    abort = 1'b0;
`endif
    step();
    step();
    chk("reset_outs", pack(), O_IDLE);
    chk("reset_count", 16'(count), 16'd0);
    chk("reset_modeq", 16'(mode_q), 16'd0);
    reset = 1'b1;

    for (int i = 0; i < 10; i++) push(1'b0, 1'b0, O_IDLE, 4'd0, 1'b0);
    push_run(1'b0, 1'b0, -1);
    push_run(1'b1, 1'b1, 4);
    push_run(1'b0, 1'b0, -1);

    for (int i = 0; i < tbl.size(); i++) begin
      start = tbl[i].start;
      mode  = tbl[i].mode;
      step();
      chk($sformatf("v%0d_outs", i), pack(), tbl[i].outs);
      chk($sformatf("v%0d_count", i), 16'(count), 16'(tbl[i].cnt));
      chk($sformatf("v%0d_modeq", i), 16'(mode_q), 16'(tbl[i].mq));
    end
    start = 1'b0;

    // Asynchronous reset while in MULR with count=3
    start = 1'b1; mode = 1'b0;
    step();
    start = 1'b0;
    for (int i = 0; i < 12; i++) step();
    chk("pre_rst_outs", pack(), O_MULR);
    chk("pre_rst_count", 16'(count), 16'd3);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_outs", pack(), O_IDLE);
    chk("async_rst_count", 16'(count), 16'd0);
    step();
    reset = 1'b1;
    step();
    run_latency(1'b0, n);
    chk("post_rst_latency", 16'(n), 16'd24);

`ifdef SERIES_ABORT_EN
    // Abort during MULX with count=2
    start = 1'b1; mode = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 8; i++) step();
    chk("pre_abort_outs", pack(), O_MULX);
    chk("pre_abort_count", 16'(count), 16'd2);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_outs", pack(), O_IDLE);
    chk("abort_count", 16'(count), 16'd0);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (ready) n++;
    end
    chk("abort_no_ready", 16'(n), 16'd0);
    run_latency(1'b0, n);
    chk("post_abort_latency", 16'(n), 16'd24);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
